// File: rtl/sram_lsu.sv
// sram_lsu: load/store initiator for a 1R1W word SRAM; define SRAM_LSU_SUBWORD_EN for byte/half access (RMW stores)
module sram_lsu #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 sram_rden,
    output logic                 sram_wren,
    output logic [ADDR_SIZE-1:0] sram_addr_out,
    output logic [ADDR_SIZE-1:0] sram_addr_in,
    output logic [DATA_SIZE-1:0] sram_data_in,
    input  logic [DATA_SIZE-1:0] sram_data_out
);
`ifdef SRAM_LSU_SUBWORD_EN
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, RMW_WR, WR_DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR_DONE = 3'd4} state_t;
`endif
    state_t state_q, state_d;
    logic ready_q, ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic rden_q, rden_d, wren_q, wren_d, err_q, err_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d, din_q, din_d, load_val;
    logic [ADDR_SIZE-1:0] raddr_q, raddr_d, waddr_q, waddr_d, aligned;
    logic accept, bad, sub;
    assign accept  = req_valid && ready_q && state_q == IDLE;
    assign aligned = {req_addr[ADDR_SIZE-1:2], 2'b00};
`ifdef SRAM_LSU_SUBWORD_EN
    logic we_q, uns_q;
    logic [1:0] size_q, lane_q;
    logic [15:0] st_q;
    logic [DATA_SIZE-1:0] shifted, mask, ins, merged;
    assign sub      = req_size != 2'b10;
    assign bad      = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign shifted  = sram_data_out >> {lane_q, 3'b000};
    assign load_val = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                      size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : sram_data_out;
    assign mask     = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << {lane_q, 3'b000};
    assign ins      = size_q == 2'b00 ? {4{st_q[7:0]}} : {2{st_q}};
    assign merged   = (sram_data_out & ~mask) | (ins & mask);
    // Request fields needed after acceptance for lane select, extension and merge
    always_ff @(posedge clock) begin
        if (accept) begin
            we_q   <= req_we;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            lane_q <= req_addr[1:0];
            st_q   <= req_wdata[15:0];
        end
    end
`else
    logic unused_ok;
    assign sub       = 1'b0;
    assign bad       = req_size != 2'b10 || req_addr[1:0] != 2'b00;
    assign load_val  = sram_data_out;
    assign unused_ok = req_unsigned;
`endif
    // State and registered outputs; req_ready resets high, everything else low
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
            err_q        <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            rden_q       <= rden_d;
            wren_q       <= wren_d;
            err_q        <= err_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            din_q        <= din_d;
        end
    end
    // Next state: reads pass RD_WAIT/RD_CAP, writes and errors finish via WR_DONE/RMW_WR
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : bad ? WR_DONE : (!req_we || sub) ? RD_WAIT : WR_DONE;
            RD_WAIT: state_d = RD_CAP;
`ifdef SRAM_LSU_SUBWORD_EN
            RD_CAP:  state_d = we_q ? RMW_WR : IDLE;
`else
            RD_CAP:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end
    // Output next values; IDLE with req_ready low is the response cycle that re-arms req_ready
    always_comb begin
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
        rden_d       = 1'b0;
        wren_d       = 1'b0;
        err_d        = err_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        din_d        = din_q;
        case (state_q)
            IDLE: begin
                ready_d = ready_q ? !accept : 1'b1;
                if (accept) begin
                    err_d   = bad;
                    rden_d  = !bad && (!req_we || sub);
                    wren_d  = !bad && req_we && !sub;
                    raddr_d = bad ? raddr_q : aligned;
                    waddr_d = bad ? waddr_q : aligned;
                    din_d   = (bad || sub || !req_we) ? din_q : req_wdata;
                end
            end
            RD_WAIT: begin
            end
            RD_CAP: begin
`ifdef SRAM_LSU_SUBWORD_EN
                wren_d       = we_q;
                din_d        = we_q ? merged : din_q;
                resp_valid_d = !we_q;
                rdata_d      = we_q ? '0 : load_val;
`else
                resp_valid_d = 1'b1;
                rdata_d      = load_val;
`endif
            end
            default: begin
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
            end
        endcase
    end
    assign req_ready     = ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = rdata_q;
    assign sram_rden     = rden_q;
    assign sram_wren     = wren_q;
    assign sram_addr_out = raddr_q;
    assign sram_addr_in  = waddr_q;
    assign sram_data_in  = din_q;
endmodule
